micro_sequencer: RTL and testbench

Microprogram sequencer for the Am2901 ALU slice. Each cycle it produces the next microcode ROM address. The ROM word carries the slice opcode/register fields plus this block's `i`, `ccen_n`, `rld_n` and `d` fields. Condition input comes from an external mux over the slice flags (`z`, `ovr`, `f3`, `cout`). Implements a 10-instruction subset of the classic 2910 instruction set, with a micro-PC, a LIFO stack and a loop counter.

---
 rtl/micro_seq_pkg.sv | 13 +
 rtl/micro_stack.sv | 43 ++++
 rtl/micro_sequencer.sv | 86 ++++++++
 tb/tb_micro_sequencer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/micro_seq_pkg.sv
// rtl/micro_seq_pkg.sv - opcode constants for the micro_sequencer instruction subset
package micro_seq_pkg;
  localparam logic [3:0] OP_JZ   = 4'h0;
  localparam logic [3:0] OP_CJS  = 4'h1;
  localparam logic [3:0] OP_CJP  = 4'h3;
  localparam logic [3:0] OP_PUSH = 4'h4;
  localparam logic [3:0] OP_RFCT = 4'h8;
  localparam logic [3:0] OP_RPCT = 4'h9;
  localparam logic [3:0] OP_CRTN = 4'hA;
  localparam logic [3:0] OP_LDCT = 4'hC;
  localparam logic [3:0] OP_LOOP = 4'hD;
  localparam logic [3:0] OP_CONT = 4'hE;
endpackage

// File: rtl/micro_stack.sv
// rtl/micro_stack.sv - saturating LIFO for return addresses and loop starts
module micro_stack #(
  parameter int AW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clr,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] tos,
  output logic          full
);
  localparam int SPW = $clog2(DEPTH + 1);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  logic [AW-1:0]  mem [DEPTH];
  logic [SPW-1:0] sp;
  logic [SPW-1:0] rd_idx;
  logic [SPW-1:0] wr_idx;

  // An empty stack still reads slot 0; a full stack rewrites the top slot.
  assign rd_idx = (sp == '0) ? '0 : sp - 1'b1;
  assign wr_idx = full ? SP_FULL - 1'b1 : sp;
  assign full   = (sp == SP_FULL);
  assign tos    = mem[IW'(rd_idx)];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= '0;
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (clr) begin
      sp <= '0;
    end else if (push) begin
      mem[IW'(wr_idx)] <= din;
      if (!full) sp <= sp + 1'b1;
    end else if (pop && sp != '0) begin
      sp <= sp - 1'b1;
    end
  end
endmodule

// File: rtl/micro_sequencer.sv
// rtl/micro_sequencer.sv - microprogram sequencer: decode, y mux, micro-PC and loop counter
module micro_sequencer
  import micro_seq_pkg::*;
#(
  parameter int AW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          cp,
  input  logic          reset,
  input  logic [3:0]    i,
  input  logic          cc_n,
  input  logic          ccen_n,
  input  logic          rld_n,
  input  logic          ci,
  input  logic [AW-1:0] d,
  output logic [AW-1:0] y,
  output logic          full_n,
  output logic          cnt_zero
);
  logic [AW-1:0] upc;
  logic [AW-1:0] cnt;
  logic [AW-1:0] tos;
  logic [AW-1:0] y_mux;
  logic          pass;
  logic          cnt_nz;
  logic          push;
  logic          pop;
  logic          clr;
  logic          ld;
  logic          dec;
  logic          full;

  assign pass   = ccen_n | ~cc_n;
  assign cnt_nz = |cnt;

  always_comb begin
    y_mux = upc;
    push  = 1'b0;
    pop   = 1'b0;
    clr   = 1'b0;
    ld    = 1'b0;
    dec   = 1'b0;
    case (i)
      OP_JZ:   begin y_mux = '0; clr = 1'b1; end
      OP_CJS:  if (pass) begin y_mux = d; push = 1'b1; end
      OP_CJP:  if (pass) y_mux = d;
      OP_PUSH: begin push = 1'b1; ld = pass; end
      OP_RFCT: if (cnt_nz) begin y_mux = tos; dec = 1'b1; end
               else pop = 1'b1;
      OP_RPCT: if (cnt_nz) begin y_mux = d; dec = 1'b1; end
      OP_CRTN: if (pass) begin y_mux = tos; pop = 1'b1; end
      OP_LDCT: ld = 1'b1;
      OP_LOOP: if (pass) pop = 1'b1;
               else y_mux = tos;
      OP_CONT: y_mux = upc;
      default: y_mux = upc;
    endcase
  end

  assign y        = reset ? '0 : y_mux;
  assign full_n   = ~full;
  assign cnt_zero = ~cnt_nz;

  always_ff @(posedge cp or posedge reset) begin
    if (reset) upc <= '0;
    else       upc <= y + AW'(ci);
  end

  // External load wins over everything; decrement is only requested while cnt is non-zero.
  always_ff @(posedge cp or posedge reset) begin
    if (reset)            cnt <= '0;
    else if (!rld_n || ld) cnt <= d;
    else if (dec)         cnt <= cnt - 1'b1;
  end

  micro_stack #(.AW(AW), .DEPTH(DEPTH)) u_stack (
    .clk  (cp),
    .rst  (reset),
    .push (push),
    .pop  (pop),
    .clr  (clr),
    .din  (upc),
    .tos  (tos),
    .full (full)
  );
endmodule

// File: tb/tb_micro_sequencer.sv
// tb/tb_micro_sequencer.sv - scoreboard bench for micro_sequencer against a behavioural model
module tb_micro_sequencer;
  localparam int DEPTH = 4;

  logic       cp;
  logic       reset;
  logic [3:0] i;
  logic       cc_n, ccen_n, rld_n, ci;
  logic [7:0] d;
  logic [7:0] y;
  logic       full_n, cnt_zero;

  typedef struct packed {
    logic [7:0] y;
    logic       full_n;
    logic       cnt_zero;
  } exp_t;

  exp_t exp_q[$];
  int   total  = 0;
  int   passed = 0;

  int         m_upc, m_cnt, m_sp;
  logic [7:0] m_mem [DEPTH];

  micro_sequencer #(.AW(8), .DEPTH(DEPTH)) dut (
    .cp(cp), .reset(reset), .i(i), .cc_n(cc_n), .ccen_n(ccen_n),
    .rld_n(rld_n), .ci(ci), .d(d), .y(y), .full_n(full_n), .cnt_zero(cnt_zero)
  );

  initial cp = 1'b0;
  always #5 cp = ~cp;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_upc = 0;
    m_cnt = 0;
    m_sp  = 0;
    for (int k = 0; k < DEPTH; k++) m_mem[k] = 8'h00;
  endtask

  task automatic model_eval(input logic [3:0] op, input bit ccn, input bit ccenn,
                            input bit rldn, input bit c, input logic [7:0] dd, output exp_t e);
    bit pass, pu, po, clr;
    int tos, ey, nc;
    pass = ccenn || !ccn;
    tos  = (m_sp == 0) ? int'(m_mem[0]) : int'(m_mem[m_sp-1]);
    ey   = m_upc;
    nc   = m_cnt;
    pu   = 0; po = 0; clr = 0;
    e.full_n   = (m_sp != DEPTH);
    e.cnt_zero = (m_cnt == 0);
    case (op)
      4'h0: begin ey = 0; clr = 1; end
      4'h1: if (pass) begin ey = dd; pu = 1; end
      4'h3: if (pass) ey = dd;
      4'h4: begin pu = 1; if (pass) nc = dd; end
      4'h8: if (m_cnt != 0) begin ey = tos; nc = m_cnt - 1; end else po = 1;
      4'h9: if (m_cnt != 0) begin ey = dd; nc = m_cnt - 1; end
      4'hA: if (pass) begin ey = tos; po = 1; end
      4'hC: nc = dd;
      4'hD: if (pass) po = 1; else ey = tos;
      default: ;
    endcase
    if (!rldn) nc = dd;
    if (clr) m_sp = 0;
    else if (pu) begin
      if (m_sp == DEPTH) m_mem[DEPTH-1] = 8'(m_upc);
      else begin m_mem[m_sp] = 8'(m_upc); m_sp++; end
    end else if (po && m_sp > 0) m_sp--;
    e.y   = 8'(ey);
    m_upc = (ey + int'(c)) % 256;
    m_cnt = nc;
  endtask

  // Drive one instruction just after the rising edge and queue what the model predicts.
  task automatic step(input bit rs, input logic [3:0] op, input bit ccn, input bit ccenn,
                      input bit rldn, input bit c, input logic [7:0] dd);
    exp_t e;
    reset = rs; i = op; cc_n = ccn; ccen_n = ccenn; rld_n = rldn; ci = c; d = dd;
    if (rs) begin
      model_reset();
      e.y = 8'h00; e.full_n = 1'b1; e.cnt_zero = 1'b1;
    end else begin
      model_eval(op, ccn, ccenn, rldn, c, dd, e);
    end
    exp_q.push_back(e);
    @(posedge cp); #1;
  endtask

  task automatic op_step(input logic [3:0] op, input bit ccn, input logic [7:0] dd);
    step(0, op, ccn, 1'b0, 1'b1, 1'b1, dd);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge cp);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("y", int'(y), int'(e.y));
        check("full_n", int'(full_n), int'(e.full_n));
        check("cnt_zero", int'(cnt_zero), int'(e.cnt_zero));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin : stim
    reset = 1'b1; i = 4'hE; cc_n = 1'b1; ccen_n = 1'b1; rld_n = 1'b1; ci = 1'b1; d = 8'h00;
    model_reset();
    repeat (2) @(posedge cp);
    #1;
    for (int k = 0; k < 4; k++) op_step(4'hE, 1'b1, 8'h00);
    step(1, 4'hE, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
    op_step(4'hE, 1'b1, 8'h00);
    // CJS/CRTN pass, then CJS fail, around upc = 0x10
    op_step(4'h3, 1'b0, 8'h0F);
    op_step(4'h1, 1'b0, 8'h40);
    op_step(4'hA, 1'b0, 8'h00);
    op_step(4'h3, 1'b0, 8'h0F);
    op_step(4'h1, 1'b1, 8'h40);
    op_step(4'hE, 1'b1, 8'h00);
    // LDCT 3 then RPCT loop
    op_step(4'hC, 1'b1, 8'h03);
    for (int k = 0; k < 4; k++) op_step(4'h9, 1'b1, 8'h20);
    op_step(4'hE, 1'b1, 8'h00);
    // PUSH/RFCT loop at upc = 0x05
    op_step(4'h3, 1'b0, 8'h04);
    op_step(4'h4, 1'b0, 8'h02);
    for (int k = 0; k < 3; k++) op_step(4'h8, 1'b1, 8'h00);
    op_step(4'hE, 1'b1, 8'h00);
    // Stack overflow then underflow
    for (int k = 0; k < 5; k++) op_step(4'h1, 1'b0, 8'(8'h30 + 8'(k * 16)));
    for (int k = 0; k < 6; k++) op_step(4'hA, 1'b0, 8'h00);
    // rld_n overrides RPCT decrement
    op_step(4'hC, 1'b1, 8'h05);
    step(0, 4'h9, 1'b1, 1'b0, 1'b0, 1'b1, 8'h09);
    for (int k = 0; k < 3; k++) op_step(4'h9, 1'b1, 8'h60);
    // JZ with a non-empty stack, then LOOP and CRTN on empty stack
    op_step(4'h1, 1'b0, 8'h70);
    op_step(4'h1, 1'b0, 8'h80);
    op_step(4'h0, 1'b1, 8'h55);
    op_step(4'hD, 1'b1, 8'h00);
    op_step(4'hA, 1'b0, 8'h00);
    // Randomised phase
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 49) == 0, 4'($urandom_range(0, 15)), 1'($urandom),
           1'($urandom), $urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
           8'($urandom));
    end
    step(0, 4'hE, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
    for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(posedge cp);
    check("drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
